// File: rtl/snax_gemm_job_sequencer.sv
// snax_gemm_job_sequencer
// Queues GEMM job descriptors from the CSR side and issues them one at a time
// to the block-GEMM control port. Each issued job is tracked by its expected
// output-beat count (M*N); once all beats are seen and the GEMM is idle, a
// one-cycle done pulse is produced and the next descriptor is taken.
//
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   desc_{k,n,m,sub}_i, desc_valid_i   descriptor push (accepted when desc_ready_o)
//   desc_ready_o                       queue not full
//   flush_i                            drop all queued descriptors (IDLE only)
//   gemm_{k,n,m,sub}_o, gemm_valid_o   job fields / valid to GEMM control
//   gemm_ready_i, gemm_busy_i          GEMM control ready / busy status
//   out_fire_i                         one GEMM output beat accepted
//   busy_o, done_o, jobs_done_o        status, job-complete pulse, job counter
//   fifo_count_o                       queued descriptors
//   err_o                              sticky {stray_beat, zero_dim}
module snax_gemm_job_sequencer #(
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned FifoDepth    = 4,
  parameter int unsigned CntWidth     = $clog2(FifoDepth + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [RegDataWidth-1:0] desc_k_i,
  input  logic [RegDataWidth-1:0] desc_n_i,
  input  logic [RegDataWidth-1:0] desc_m_i,
  input  logic [RegDataWidth-1:0] desc_sub_i,
  input  logic                    desc_valid_i,
  output logic                    desc_ready_o,
  input  logic                    flush_i,
  output logic [RegDataWidth-1:0] gemm_k_o,
  output logic [RegDataWidth-1:0] gemm_n_o,
  output logic [RegDataWidth-1:0] gemm_m_o,
  output logic [RegDataWidth-1:0] gemm_sub_o,
  output logic                    gemm_valid_o,
  input  logic                    gemm_ready_i,
  input  logic                    gemm_busy_i,
  input  logic                    out_fire_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [RegDataWidth-1:0] jobs_done_o,
  output logic [CntWidth-1:0]     fifo_count_o,
  output logic [1:0]              err_o
);

  localparam int unsigned PtrWidth = $clog2(FifoDepth);

  typedef struct packed {
    logic [RegDataWidth-1:0] k;
    logic [RegDataWidth-1:0] n;
    logic [RegDataWidth-1:0] m;
    logic [RegDataWidth-1:0] sub;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  desc_t                   fifo_mem [FifoDepth];
  logic [PtrWidth-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]     count_q, count_d;
  logic                    ready_q;
  state_e                  state_q;
  logic [RegDataWidth-1:0] beat_cnt_q;
  logic [RegDataWidth-1:0] jobs_done_q;
  logic [1:0]              err_q;

  desc_t desc_in;
  desc_t head;
  logic  empty;
  logic  head_zero;
  logic  flush;
  logic  push;
  logic  pop;

  // Queue control: flush has priority and also swallows a same-cycle push.
  always_comb begin
    desc_in   = '{k: desc_k_i, n: desc_n_i, m: desc_m_i, sub: desc_sub_i};
    empty     = (count_q == '0);
    head      = empty ? '0 : fifo_mem[rd_ptr_q];
    head_zero = (head.k == '0) || (head.n == '0) || (head.m == '0);
    flush     = (state_q == IDLE) && flush_i;
    push      = desc_valid_i && ready_q && !flush;
    pop       = !flush && !empty &&
                (((state_q == IDLE) && head_zero) ||
                 ((state_q == ISSUE) && gemm_ready_i));
    count_d   = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CntWidth'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntWidth'(1);
    end
  end

  // Pointers, occupancy and registered ready (derived from next occupancy so
  // it never depends on a same-cycle pop).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d != CntWidth'(FifoDepth));
    end
  end

  // Descriptor storage; contents are only observed while occupied.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= desc_in;
  end

  // Job FSM with beat tracking and sticky error flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      jobs_done_q <= '0;
      err_q       <= 2'b00;
    end else begin
      // Any beat not consumed by a running job with beats outstanding is stray.
      if (out_fire_i && !((state_q == RUN) && (beat_cnt_q != '0))) begin
        err_q[1] <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (!flush_i && !empty) begin
            if (head_zero) err_q[0] <= 1'b1;
            else           state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (gemm_ready_i) begin
            beat_cnt_q <= head.m * head.n;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (out_fire_i && (beat_cnt_q != '0)) begin
            beat_cnt_q <= beat_cnt_q - RegDataWidth'(1);
          end
          // Count bumps on DONE entry so jobs_done_o is current while done_o is high.
          if ((beat_cnt_q == '0) && !gemm_busy_i) begin
            state_q     <= DONE;
            jobs_done_q <= jobs_done_q + RegDataWidth'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign desc_ready_o = ready_q;
  assign gemm_k_o     = head.k;
  assign gemm_n_o     = head.n;
  assign gemm_m_o     = head.m;
  assign gemm_sub_o   = head.sub;
  assign gemm_valid_o = (state_q == ISSUE);
  assign done_o       = (state_q == DONE);
  assign busy_o       = (state_q != IDLE) || !empty;
  assign jobs_done_o  = jobs_done_q;
  assign fifo_count_o = count_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_snax_gemm_job_sequencer.sv
// Bench for snax_gemm_job_sequencer: directed jobs, expected issues and
// job-complete counts queued by the stimulus, checked by a negedge monitor.
module tb_snax_gemm_job_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic [W-1:0] k;
    logic [W-1:0] n;
    logic [W-1:0] m;
    logic [W-1:0] s;
  } desc_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [W-1:0]  desc_k_i, desc_n_i, desc_m_i, desc_sub_i;
  logic          desc_valid_i, desc_ready_o, flush_i;
  logic [W-1:0]  gemm_k_o, gemm_n_o, gemm_m_o, gemm_sub_o;
  logic          gemm_valid_o, gemm_ready_i, gemm_busy_i, out_fire_i;
  logic          busy_o, done_o;
  logic [W-1:0]  jobs_done_o;
  logic [CW-1:0] fifo_count_o;
  logic [1:0]    err_o;

  snax_gemm_job_sequencer #(.RegDataWidth(W), .FifoDepth(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .desc_k_i(desc_k_i), .desc_n_i(desc_n_i), .desc_m_i(desc_m_i),
    .desc_sub_i(desc_sub_i), .desc_valid_i(desc_valid_i),
    .desc_ready_o(desc_ready_o), .flush_i(flush_i),
    .gemm_k_o(gemm_k_o), .gemm_n_o(gemm_n_o), .gemm_m_o(gemm_m_o),
    .gemm_sub_o(gemm_sub_o), .gemm_valid_o(gemm_valid_o),
    .gemm_ready_i(gemm_ready_i), .gemm_busy_i(gemm_busy_i),
    .out_fire_i(out_fire_i), .busy_o(busy_o), .done_o(done_o),
    .jobs_done_o(jobs_done_o), .fifo_count_o(fifo_count_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  desc_t        exp_issue[$];
  logic [W-1:0] exp_done[$];
  desc_t        mon_e;
  int           total = 0;
  int           bad = 0;
  int           done_cnt = 0;
  int           valid_seen = 0;
  int           exp_jobs = 0;
  int           snap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: checks every issue handshake and every done pulse against the queues.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (gemm_valid_o) valid_seen++;
      if (gemm_valid_o && gemm_ready_i) begin
        if (exp_issue.size() == 0) begin
          total++; bad++;
          $display("FAIL issue_unexpected: got k=%0d n=%0d m=%0d, expected no issue",
                   gemm_k_o, gemm_n_o, gemm_m_o);
        end else begin
          mon_e = exp_issue.pop_front();
          chk("issue_k", 64'(gemm_k_o), 64'(mon_e.k));
          chk("issue_n", 64'(gemm_n_o), 64'(mon_e.n));
          chk("issue_m", 64'(gemm_m_o), 64'(mon_e.m));
          chk("issue_sub", 64'(gemm_sub_o), 64'(mon_e.s));
        end
      end
      if (done_o) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got done with jobs_done=%0d, expected no done", jobs_done_o);
        end else begin
          chk("done_jobs", 64'(jobs_done_o), 64'(exp_done.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    desc_k_i = '0; desc_n_i = '0; desc_m_i = '0; desc_sub_i = '0;
    desc_valid_i = 1'b0; flush_i = 1'b0; gemm_ready_i = 1'b0;
    gemm_busy_i = 1'b0; out_fire_i = 1'b0;
    exp_issue.delete(); exp_done.delete();
    exp_jobs = 0; done_cnt = 0;
    repeat (2) tick();
    chk("rst_ready", 64'(desc_ready_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_valid", 64'(gemm_valid_o), 64'(0));
    chk("rst_state_outs", {30'd0, err_o, jobs_done_o}, 64'(0));
    chk("rst_count", 64'(fifo_count_o), 64'(0));
    rst_i = 1'b0;
    tick();
    chk("rel_ready", 64'(desc_ready_o), 64'(1));
  endtask

  task automatic push(input logic [W-1:0] k, input logic [W-1:0] n,
                      input logic [W-1:0] m, input logic [W-1:0] s, input bit expect_issue);
    desc_k_i = k; desc_n_i = n; desc_m_i = m; desc_sub_i = s;
    if (expect_issue) exp_issue.push_back('{k: k, n: n, m: m, s: s});
    desc_valid_i = 1'b1;
    tick();
    desc_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!gemm_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk(name, 64'(gemm_valid_o), 64'(1));
  endtask

  task automatic handshake();
    gemm_ready_i = 1'b1;
    tick();
    gemm_ready_i = 1'b0;
  endtask

  task automatic fire(input int n);
    repeat (n) begin
      out_fire_i = 1'b1;
      tick();
    end
    out_fire_i = 1'b0;
  endtask

  task automatic expect_job();
    exp_jobs++;
    exp_done.push_back(W'(exp_jobs));
  endtask

  task automatic wait_done(input string name, input int target);
    int n = 0;
    while (done_cnt < target && n < 40) begin
      tick();
      n++;
    end
    chk(name, 64'(done_cnt), 64'(target));
  endtask

  int beats [4] = '{1, 1, 2, 3};

  initial begin
    // Single job: issue latency and beat counting.
    do_reset();
    repeat (8) tick();
    push(2, 2, 2, 0, 1'b1);
    chk("lat_t1_valid", 64'(gemm_valid_o), 64'(0));
    chk("lat_t1_count", 64'(fifo_count_o), 64'(1));
    tick();
    chk("lat_t2_valid", 64'(gemm_valid_o), 64'(1));
    expect_job();
    handshake();
    gemm_busy_i = 1'b1;
    fire(4);
    chk("t1_err", 64'(err_o), 64'(0));
    gemm_busy_i = 1'b0;
    wait_done("t1_done", 1);
    repeat (3) tick();
    chk("t1_single_done", 64'(done_cnt), 64'(1));
    chk("t1_jobs", 64'(jobs_done_o), 64'(1));
    chk("t1_idle", 64'(busy_o), 64'(0));

    // Fill the queue while GEMM stalls; a fifth push is refused.
    do_reset();
    push(1, 1, 1, 1, 1'b1);
    push(2, 1, 1, 2, 1'b1);
    push(1, 1, 2, 3, 1'b1);
    push(3, 3, 1, 4, 1'b1);
    chk("full_count", 64'(fifo_count_o), 64'(4));
    chk("full_ready", 64'(desc_ready_o), 64'(0));
    push(9, 9, 9, 9, 1'b0);
    chk("full_reject", 64'(fifo_count_o), 64'(4));
    chk("full_head_k", 64'(gemm_k_o), 64'(1));
    handshake();
    chk("pop_count", 64'(fifo_count_o), 64'(3));
    chk("pop_ready", 64'(desc_ready_o), 64'(1));
    expect_job();
    fire(beats[0]);
    wait_done("fill_done0", 1);
    for (int i = 1; i < 4; i++) begin
      wait_valid("fill_valid");
      expect_job();
      handshake();
      fire(beats[i]);
      wait_done("fill_done", i + 1);
    end
    chk("fill_jobs", 64'(jobs_done_o), 64'(4));
    chk("fill_err", 64'(err_o), 64'(0));

    // Zero-dimension descriptor is dropped; the next one issues normally.
    do_reset();
    push(2, 2, 0, 5, 1'b0);
    push(1, 2, 3, 7, 1'b1);
    wait_valid("zero_valid");
    chk("zero_err", 64'(err_o), 64'(1));
    chk("zero_head_m", 64'(gemm_m_o), 64'(3));
    expect_job();
    handshake();
    fire(6);
    wait_done("zero_done", 1);
    chk("zero_jobs", 64'(jobs_done_o), 64'(1));
    fire(1);
    chk("idle_stray", 64'(err_o), 64'(3));

    // Stray beat after count exhausted while GEMM still busy.
    do_reset();
    push(1, 1, 2, 0, 1'b1);
    wait_valid("stray_valid");
    expect_job();
    handshake();
    gemm_busy_i = 1'b1;
    fire(3);
    chk("stray_err", 64'(err_o), 64'(2));
    repeat (3) tick();
    chk("stray_no_done", 64'(done_cnt), 64'(0));
    gemm_busy_i = 1'b0;
    wait_done("stray_done", 1);
    repeat (3) tick();
    chk("stray_single_done", 64'(done_cnt), 64'(1));

    // Reset in the middle of a running job with two descriptors queued.
    do_reset();
    push(1, 1, 4, 0, 1'b1);
    wait_valid("mid_valid");
    handshake();
    push(1, 1, 1, 0, 1'b0);
    push(1, 1, 1, 0, 1'b0);
    chk("mid_count", 64'(fifo_count_o), 64'(2));
    chk("mid_busy", 64'(busy_o), 64'(1));
    rst_i = 1'b1;
    #1;
    chk("mid_rst_count", 64'(fifo_count_o), 64'(0));
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    chk("mid_rst_valid_done", {62'd0, gemm_valid_o, done_o}, 64'(0));
    chk("mid_rst_ready", 64'(desc_ready_o), 64'(0));
    chk("mid_rst_k", 64'(gemm_k_o), 64'(0));
    exp_issue.delete();
    tick();
    rst_i = 1'b0;
    repeat (10) tick();
    chk("mid_no_done", 64'(done_cnt), 64'(0));
    chk("mid_jobs", 64'(jobs_done_o), 64'(0));

    // Flush in IDLE with three queued plus a simultaneous push.
    do_reset();
    push(1, 1, 1, 0, 1'b1);
    wait_valid("flush_pre_valid");
    expect_job();
    handshake();
    gemm_busy_i = 1'b1;
    fire(1);
    push(4, 4, 4, 0, 1'b0);
    push(5, 5, 5, 0, 1'b0);
    push(6, 6, 6, 0, 1'b0);
    chk("flush_pre_count", 64'(fifo_count_o), 64'(3));
    gemm_busy_i = 1'b0;
    tick();
    chk("flush_done_pulse", 64'(done_o), 64'(1));
    tick();
    snap = valid_seen;
    flush_i = 1'b1;
    desc_k_i = 7; desc_n_i = 7; desc_m_i = 7; desc_sub_i = 7;
    desc_valid_i = 1'b1;
    tick();
    flush_i = 1'b0;
    desc_valid_i = 1'b0;
    chk("flush_count", 64'(fifo_count_o), 64'(0));
    chk("flush_busy", 64'(busy_o), 64'(0));
    repeat (6) tick();
    chk("flush_no_valid", 64'(valid_seen - snap), 64'(0));
    chk("flush_jobs", 64'(jobs_done_o), 64'(1));

    chk("issue_q_empty", 64'(exp_issue.size()), 64'(0));
    chk("done_q_empty", 64'(exp_done.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snax_gemm_job_sequencer.md
Name: snax_gemm_job_sequencer

Overview:
Queues GEMM job descriptors (K, N, M, subtraction constant) written by the CSR side and issues them one at a time to the block-GEMM control port. It tracks each job's output-beat count until completion, then pulses done and advances to the next job. It sits between the CSR manager and the GEMM accelerator shell, so software can batch several tiles without polling between them.

Parameters:
RegDataWidth, 32, width of each descriptor field and of the counters
FifoDepth, 4, descriptor queue depth (power of two, >=2)
CntWidth, $clog2(FifoDepth+1), width of fifo_count_o

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
desc_k_i  in  RegDataWidth  job K
desc_n_i  in  RegDataWidth  job N
desc_m_i  in  RegDataWidth  job M
desc_sub_i  in  RegDataWidth  subtraction constant
desc_valid_i  in  1  descriptor push request
desc_ready_o  out  1  queue not full
flush_i  in  1  drop all queued descriptors (honoured in IDLE only)
gemm_k_o / gemm_n_o / gemm_m_o / gemm_sub_o  out  RegDataWidth each  fields to GEMM ctrl
gemm_valid_o  out  1  GEMM ctrl valid
gemm_ready_i  in  1  GEMM ctrl ready
gemm_busy_i  in  1  GEMM busy status
out_fire_i  in  1  GEMM output beat accepted (d_o valid & ready)
busy_o  out  1  state != IDLE or queue non-empty
done_o  out  1  one-cycle job-complete pulse
jobs_done_o  out  RegDataWidth  completed-job counter
fifo_count_o  out  CntWidth  queued descriptors
err_o  out  2  sticky {stray_beat, zero_dim}

Behaviour:
- Reset (async, rst_i=1): state IDLE, FIFO empty, all outputs 0, desc_ready_o=0 while rst_i is high and 1 in the first cycle after release. Reset mid-job abandons the job without a done pulse.
- FIFO: push when desc_valid_i & desc_ready_o. desc_ready_o = !full, with no dependence on the pop in the same cycle. Simultaneous push and pop is legal and count is unchanged. No bypass: a descriptor pushed in cycle t is visible to the FSM in t+1.
- gemm_*_o fields are driven from the FIFO head and are 0 when the FIFO is empty.
- States: IDLE, ISSUE, RUN, DONE.
- IDLE:
  - flush_i=1: FIFO cleared and no issue that cycle. A push in the same cycle is also dropped.
  - Else, if non-empty and any of K/N/M at the head is 0: pop the head, set err_o[0], stay in IDLE.
  - Else, if non-empty: go to ISSUE.
- ISSUE:
  - gemm_valid_o=1, with fields stable from the head.
  - On gemm_ready_i: pop, load beat_cnt = M*N (low RegDataWidth bits; software guarantees M*N < 2^RegDataWidth), go to RUN.
  - gemm_valid_o never drops before ready.
- RUN:
  - beat_cnt decrements on out_fire_i.
  - When beat_cnt==0 and gemm_busy_i==0 in the same cycle: go to DONE.
  - A beat arriving while beat_cnt==0 sets err_o[1] and the counter stays at 0.
- DONE: done_o=1 for exactly one cycle, jobs_done_o increments (wraps at 2^RegDataWidth), next state IDLE.
- Issue latency: descriptor pushed into an empty idle block in cycle t gives gemm_valid_o=1 in t+2. Back-to-back jobs see a 2-cycle gap (DONE, IDLE) between the RUN exit and the next ISSUE.
- out_fire_i in IDLE/ISSUE/DONE: sets err_o[1] and is not counted.
- err_o bits are sticky until reset.
- busy_o = (state!=IDLE) | (fifo_count_o!=0).

Test Plan:
- Push K=2,N=2,M=2,sub=0 into an idle block at cycle 10 -> gemm_valid_o=1 at cycle 12. With gemm_ready_i=1 the block enters RUN. Four out_fire_i pulses, then busy low -> done_o pulses once, jobs_done_o=1.
- Fill with 4 descriptors while GEMM stalls ready=0 -> desc_ready_o=0 and fifo_count_o=4. A 5th push is not accepted. After one issue handshake, desc_ready_o=1 and fifo_count_o=3.
- Descriptor M=0 followed by a valid descriptor -> first is popped without gemm_valid_o and err_o[0]=1. Second issues normally, jobs_done_o=1.
- Extra out_fire_i after beat_cnt reaches 0, with gemm_busy_i held high -> err_o[1]=1. No DONE until busy falls, then exactly one done_o pulse.
- Assert rst_i mid-RUN with 2 queued descriptors -> all outputs 0 immediately, fifo_count_o=0, no done_o pulse.
- flush_i in IDLE with 3 queued and a simultaneous push -> fifo_count_o=0 next cycle and gemm_valid_o never asserted.
